// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: two 2-entry request FIFOs feeding one registered write port.
// Define WB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority (requester 0 first).
module regfile_wb_arbiter (
  input  logic        Clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_rd,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_rd,
  input  logic [31:0] req1_data,
  output logic        WEN,
  output logic [4:0]  RW,
  output logic [31:0] busW,
  output logic [31:0] pend_mask
);
  localparam int NREQ = 2;
  localparam int DEPTH = 2;

  logic [NREQ-1:0]                   vld, rdy, push, pop, ne;
  logic [NREQ-1:0][4:0]              in_rd;
  logic [NREQ-1:0][31:0]             in_dat;
  logic [NREQ-1:0][1:0]              cnt_q;
  logic [NREQ-1:0][DEPTH-1:0][4:0]   rd_q;
  logic [NREQ-1:0][DEPTH-1:0][31:0]  dat_q;
  logic                              alive_q, any, gnt;
  logic                              wen_q;
  logic [4:0]                        rw_q, sel_rd;
  logic [31:0]                       busw_q, sel_dat;

  assign vld    = {req1_valid, req0_valid};
  assign in_rd  = {req1_rd, req0_rd};
  assign in_dat = {req1_data, req0_data};

  // alive_q keeps ready low while in reset and for the edge that releases it
  always_comb begin
    for (int n = 0; n < NREQ; n++) begin
      rdy[n]  = alive_q && (cnt_q[n] != 2'd2);
      push[n] = vld[n] && rdy[n];
      ne[n]   = (cnt_q[n] != 2'd0);
    end
  end
  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];
  assign any = |ne;

`ifdef WB_ROUND_ROBIN_EN
  logic last_q;
  assign gnt = (ne == 2'b11) ? ~last_q : ~ne[0];

  always_ff @(posedge Clk or negedge rst)
    if (!rst)     last_q <= 1'b1;
    else if (any) last_q <= gnt;
`else
  assign gnt = ~ne[0];
`endif

  always_comb begin
    pop = '0;
    pop[gnt] = any;
  end

  // Slot 0 is the head; a push lands behind whatever survives this cycle's pop
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      alive_q <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
      dat_q   <= '0;
    end else begin
      alive_q <= 1'b1;
      for (int n = 0; n < NREQ; n++) begin
        cnt_q[n] <= cnt_q[n] + {1'b0, push[n]} - {1'b0, pop[n]};
        if (pop[n]) begin
          rd_q[n][0]  <= rd_q[n][1];
          dat_q[n][0] <= dat_q[n][1];
        end
        if (push[n]) begin
          if (cnt_q[n] == 2'd0 || pop[n]) begin
            rd_q[n][0]  <= in_rd[n];
            dat_q[n][0] <= in_dat[n];
          end else begin
            rd_q[n][1]  <= in_rd[n];
            dat_q[n][1] <= in_dat[n];
          end
        end
      end
    end
  end

  assign sel_rd  = rd_q[gnt][0];
  assign sel_dat = dat_q[gnt][0];

  // rd=0 still takes the slot but writes nothing
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      wen_q  <= 1'b0;
      rw_q   <= '0;
      busw_q <= '0;
    end else if (any) begin
      wen_q  <= (sel_rd != 5'd0);
      rw_q   <= sel_rd;
      busw_q <= (sel_rd != 5'd0) ? sel_dat : 32'd0;
    end else begin
      wen_q  <= 1'b0;
    end
  end

  assign WEN  = wen_q;
  assign RW   = rw_q;
  assign busW = busw_q;

  always_comb begin
    pend_mask = '0;
    for (int n = 0; n < NREQ; n++)
      for (int s = 0; s < DEPTH; s++)
        if (cnt_q[n] > 2'(s)) pend_mask[rd_q[n][s]] = 1'b1;
    if (wen_q) pend_mask[rw_q] = 1'b1;
    pend_mask[0] = 1'b0;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low; asserting it clears all state immediately, independent of Clk.
REQ-003 req0_valid  input  1  writeback request valid, requester 0 (main pipeline).
REQ-004 req0_ready  output  1  requester 0 FIFO can accept an entry.
REQ-005 req0_rd  input  5  destination register index, requester 0.
REQ-006 req0_data  input  32  write data, requester 0.
REQ-007 req1_valid, req1_ready, req1_rd, req1_data  same directions and widths as REQ-003..006, requester 1 (multi-cycle unit).
REQ-008 WEN  output  1  register-file write enable.
REQ-009 RW  output  5  register-file write index.
REQ-010 busW  output  32  register-file write data.
REQ-011 pend_mask  output  32  bit r = 1 while a write to register r is buffered or being presented.

Function
REQ-012 Each requester SHALL own a 2-entry in-order FIFO; an entry {rd,data} is pushed on a rising edge with reqN_valid=1 and reqN_ready=1.
REQ-013 reqN_ready SHALL be 1 iff FIFO N holds fewer than 2 entries; it depends on registered state only, never on reqN_valid or on a same-cycle pop.
REQ-014 Full FIFO: ready=0 even if a pop occurs in the same cycle; valid with ready=0 SHALL push nothing.
REQ-015 Push and pop in the same cycle on a 1-entry FIFO SHALL leave count=1 with the new entry at the head.
REQ-016 Each cycle at most one FIFO head SHALL be popped into a single output stage holding {WEN,RW,busW}.
REQ-017 Output stage SHALL be registered: an entry pushed at edge N SHALL pop no earlier than edge N+1 and drive WEN/RW/busW during cycle N+1..N+2; register-file write occurs at edge N+2.
REQ-018 When no FIFO is non-empty at an edge, the output stage SHALL load WEN=0; RW and busW hold their previous values.
REQ-019 A popped entry with rd=0 SHALL consume its arbitration slot and load WEN=0, RW=0, busW=0.
REQ-020 Entries from one requester SHALL reach the output stage in push order; no ordering is guaranteed between requesters.
REQ-021 Fully pipelined: sustained throughput of one write per cycle when any FIFO is non-empty.
REQ-022 pend_mask bit r (r=1..31) SHALL be 1 iff any valid FIFO entry or the output stage with WEN=1 has rd=r; bit 0 SHALL always be 0; derived combinationally from registered state.
REQ-023 Arbitration when only one FIFO is non-empty: that FIFO SHALL be granted.

Reset
REQ-024 While rst=0: both FIFOs empty, WEN=0, RW=0, busW=0, pend_mask=0, req0_ready=req1_ready=0, last-grant pointer=1.
REQ-025 First edge after rst release: req0_ready=req1_ready=1, ready to accept.
REQ-026 Reset mid-operation SHALL discard all buffered entries; no WEN pulse SHALL result from entries pushed before reset.

Configuration
REQ-027 Macro WB_ROUND_ROBIN_EN defined: when both FIFOs are non-empty, grant the requester not granted last; the pointer updates only on a grant; after reset requester 0 wins first.
REQ-028 WB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins when non-empty; the pointer is absent.

Verification
REQ-029 Single write: after reset, req0 pushes rd=5, data=0xDEADBEEF at edge 1 -> WEN=1, RW=5, busW=0xDEADBEEF during cycle 2..3, pend_mask=0x20 from edge 1 through edge 3.
REQ-030 Contention with macro: both FIFOs hold 2 entries (req0 rd=1,2; req1 rd=3,4) -> RW sequence 1,3,2,4 on consecutive cycles; without macro -> 1,2,3,4.
REQ-031 Back-pressure: req1 pushes 2 entries while the output stage is kept busy by req0 -> req1_ready=0; a third valid is held and not pushed until ready=1.
REQ-032 rd=0 drop: req0 pushes rd=0, data=0x1234 -> output slot with WEN=0; pend_mask stays 0.
REQ-033 Reset mid-stream: rst low for 1 cycle with 3 entries buffered -> WEN=0, pend_mask=0, ready=0 during reset; no write appears after release.
